// File: rtl/vpmac_pkg.sv
// rtl/vpmac_pkg.sv - mode encodings, slot multiplier and lane-width helper for variable_precision_mac
package vpmac_pkg;

  localparam logic [1:0] MODE_4    = 2'b00;
  localparam logic [1:0] MODE_8    = 2'b01;
  localparam logic [1:0] MODE_16   = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  // Each lane's result slot is this many times the lane width.
  localparam int SLOT_MUL = 4;

  function automatic int lane_width(input logic [1:0] mode);
    case (mode)
      MODE_4:  return 4;
      MODE_8:  return 8;
      MODE_16: return 16;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/vpmac_lane_mul.sv
// rtl/vpmac_lane_mul.sv - one LW x LW lane product, sign- or zero-extended into a SLOT_MUL*LW slot
import vpmac_pkg::*;

module vpmac_lane_mul #(
  parameter int LW = 4
) (
  input  logic [LW-1:0]          a,
  input  logic [LW-1:0]          b,
  input  logic                   sgn,
  output logic [SLOT_MUL*LW-1:0] slot
);

  localparam int SW = SLOT_MUL * LW;

  logic [SW-1:0] a_ext;
  logic [SW-1:0] b_ext;

  // The full product fits in 2*LW bits, so multiplying the extended operands
  // modulo 2^SW yields the correctly extended product.
  assign a_ext = {{(SW-LW){sgn & a[LW-1]}}, a};
  assign b_ext = {{(SW-LW){sgn & b[LW-1]}}, b};
  assign slot  = a_ext * b_ext;

endmodule

// File: rtl/variable_precision_mac.sv
// rtl/variable_precision_mac.sv - two-stage variable-precision MAC; VPMAC_SAT_EN enables saturating slots
import vpmac_pkg::*;

module variable_precision_mac #(
  parameter  int DATA_W = 16,
  localparam int RES_W  = SLOT_MUL * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        mode,
  input  logic              sgn,
  input  logic              acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  result,
  output logic              sat_flag
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [1:0]        s1_mode;
  logic              s1_sgn;
  logic              s1_acc;
  logic [1:0]        held_mode;
  logic              held_sgn;

  logic              adv;
  logic              s2_wr;
  logic              do_acc;
  logic [RES_W-1:0]  old_res;
  logic [2:0][RES_W-1:0] nres;
  logic [RES_W-1:0]  next_res;

  assign adv      = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv;
  assign s2_wr    = s1_valid && adv;
  assign do_acc   = s1_acc && (s1_mode == held_mode) && (s1_sgn == held_sgn);
  assign old_res  = do_acc ? result : '0;

`ifdef VPMAC_SAT_EN
  logic [2:0] clip_any;
  logic       next_sat;
`endif

  // One full-width datapath per lane width; the held mode picks which one lands.
  for (genvar g = 0; g < 3; g++) begin : g_width
    localparam int LW = lane_width(2'(g));
    localparam int SW = SLOT_MUL * LW;
    localparam int NL = DATA_W / LW;
`ifdef VPMAC_SAT_EN
    logic [NL-1:0] lane_clip;
`endif
    for (genvar i = 0; i < NL; i++) begin : g_lane
      logic [SW-1:0] prod;
      logic [SW-1:0] old;

      vpmac_lane_mul #(.LW(LW)) u_mul (
        .a    (s1_a[i*LW +: LW]),
        .b    (s1_b[i*LW +: LW]),
        .sgn  (s1_sgn),
        .slot (prod)
      );

      assign old = old_res[i*SW +: SW];
`ifdef VPMAC_SAT_EN
      logic [SW:0] sum;
      logic        ovf;
      assign sum = {1'b0, old} + {1'b0, prod};
      assign ovf = s1_sgn ? ((old[SW-1] == prod[SW-1]) && (sum[SW-1] != old[SW-1])) : sum[SW];
      assign lane_clip[i] = ovf;
      assign nres[g][i*SW +: SW] = !ovf    ? sum[SW-1:0] :
                                   !s1_sgn ? {SW{1'b1}} :
                                   old[SW-1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
`else
      assign nres[g][i*SW +: SW] = old + prod;
`endif
    end
`ifdef VPMAC_SAT_EN
    assign clip_any[g] = |lane_clip;
`endif
  end

  always_comb begin
    next_res = '0;
    case (s1_mode)
      MODE_4:  next_res = nres[0];
      MODE_8:  next_res = nres[1];
      MODE_16: next_res = nres[2];
      default: next_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_mode   <= MODE_RSVD;
      s1_sgn    <= 1'b0;
      s1_acc    <= 1'b0;
      held_mode <= MODE_RSVD;
      held_sgn  <= 1'b0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_a     <= a;
        s1_b     <= b;
        s1_mode  <= mode;
        s1_sgn   <= sgn;
        s1_acc   <= acc;
      end else if (s2_wr) begin
        s1_valid <= 1'b0;
      end
      if (s2_wr) begin
        result    <= next_res;
        held_mode <= s1_mode;
        held_sgn  <= s1_sgn;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef VPMAC_SAT_EN
  always_comb begin
    next_sat = 1'b0;
    case (s1_mode)
      MODE_4:  next_sat = clip_any[0];
      MODE_8:  next_sat = clip_any[1];
      MODE_16: next_sat = clip_any[2];
      default: next_sat = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sat_flag <= 1'b0;
    else if (s2_wr) sat_flag <= next_sat;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_variable_precision_mac.sv
// tb/tb_variable_precision_mac.sv - directed self-checking bench for variable_precision_mac (DATA_W=16)
module tb_variable_precision_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [1:0]  mode = '0;
  logic        sgn = 1'b0;
  logic        acc = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        sat_flag;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  variable_precision_mac #(.DATA_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .sgn       (sgn),
    .acc       (acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .sat_flag  (sat_flag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // One transaction with out_ready high; checks acceptance, two-edge latency and the result.
  task automatic xact(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                      input logic [1:0] m, input logic s, input logic ac, input logic [63:0] exp);
    @(negedge clk);
    a = ta; b = tb_v; mode = m; sgn = s; acc = ac; in_valid = 1'b1;
    #1 check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({tag, "_ov"}, 64'(out_valid), 64'd1);
    check(tag, result, exp);
  endtask

  task automatic drive(input logic [15:0] ta, input logic [15:0] tb_v);
    a = ta; b = tb_v; mode = 2'b00; sgn = 1'b0; acc = 1'b0; in_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stalls;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_sat", 64'(sat_flag), 64'd0);
    rst = 1'b0;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);

    xact("m4_basic",   16'h4321, 16'h1234, 2'b00, 1'b0, 1'b0, 64'h0004_0006_0006_0004);
    xact("m16_signed", 16'hFFFF, 16'h0002, 2'b10, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    xact("m16_unsign", 16'hFFFF, 16'h0002, 2'b10, 1'b0, 1'b0, 64'h0000_0000_0001_FFFE);
    xact("m8_first",   16'h0303, 16'h0303, 2'b01, 1'b0, 1'b0, 64'h0000_0009_0000_0009);
    xact("m8_acc",     16'h0303, 16'h0303, 2'b01, 1'b0, 1'b1, 64'h0000_0012_0000_0012);
    xact("m4_switch",  16'h0303, 16'h0303, 2'b00, 1'b0, 1'b1, 64'h0000_0009_0000_0009);
    xact("m4_acc",     16'h0303, 16'h0303, 2'b00, 1'b0, 1'b1, 64'h0000_0012_0000_0012);
    xact("rsvd_mode",  16'hFFFF, 16'hFFFF, 2'b11, 1'b1, 1'b1, 64'h0);

    // 512 back-to-back signed (-8)*(-8) accumulations into lane 0.
    stalls = 0;
    @(negedge clk);
    for (int i = 0; i < 512; i++) begin
      a = 16'h0008; b = 16'h0008; mode = 2'b00; sgn = 1'b1; acc = (i != 0); in_valid = 1'b1;
      #1 if (!in_ready) stalls++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("thru_stalls", 64'(stalls), 64'd0);
    check("acc512_ov", 64'(out_valid), 64'd1);
`ifdef VPMAC_SAT_EN
    check("acc512_result", result, 64'h0000_0000_0000_7FFF);
    check("acc512_sat", 64'(sat_flag), 64'd1);
`else
    check("acc512_result", result, 64'h0000_0000_0000_8000);
    check("acc512_sat", 64'(sat_flag), 64'd0);
`endif

    // Backpressure: three back-to-back inputs with out_ready low.
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    drive(16'h0001, 16'h0001);
    #1 check("bp_rdy1", 64'(in_ready), 64'd1);
    @(negedge clk);
    drive(16'h0002, 16'h0003);
    #1 check("bp_rdy2", 64'(in_ready), 64'd1);
    @(negedge clk);
    drive(16'h0010, 16'h0010);
    #1 check("bp_rdy3", 64'(in_ready), 64'd0);
    check("bp_ov", 64'(out_valid), 64'd1);
    check("bp_res1", result, 64'h1);
    repeat (3) @(negedge clk);
    check("bp_hold_rdy", 64'(in_ready), 64'd0);
    check("bp_hold_res", result, 64'h1);
    out_ready = 1'b1;
    #1 check("bp_release_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_ov2", 64'(out_valid), 64'd1);
    check("bp_res2", result, 64'h6);
    @(negedge clk);
    check("bp_ov3", 64'(out_valid), 64'd1);
    check("bp_res3", result, 64'h0000_0000_0001_0000);
    @(negedge clk);
    check("bp_drain", 64'(out_valid), 64'd0);

    // Reset with both S1 and the output register occupied.
    out_ready = 1'b0;
    @(negedge clk);
    drive(16'h0005, 16'h0005);
    @(negedge clk);
    drive(16'h0003, 16'h0003);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_ov", 64'(out_valid), 64'd1);
    check("pre_rst_res", result, 64'h19);
    rst = 1'b1;
    #1 check("mid_rst_ov", 64'(out_valid), 64'd0);
    check("mid_rst_res", result, 64'd0);
    check("mid_rst_sat", 64'(sat_flag), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_dropped", 64'(out_valid), 64'd0);
    xact("post_rst_acc", 16'h0005, 16'h0005, 2'b00, 1'b0, 1'b1, 64'h19);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
